// File: rtl/hier_loopback_return.sv
// hier_loopback_return: two independent 3-bit valid/ready FIFOs closing the B->A and D->C loops; define HIER_LOOPBACK_BYPASS_EN for same-cycle pass-through when empty
module hier_loopback_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [2:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);
  localparam int AW = $clog2(DEPTH);
  logic [2:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic empty, byp, push, pop;
  always_comb begin
    empty = cnt_q == '0;
`ifdef HIER_LOOPBACK_BYPASS_EN
    byp = empty && in_valid_i;
`else
    byp = 1'b0;
`endif
    in_ready_o = cnt_q != (AW+1)'(DEPTH);
    out_valid_o = !empty || byp;
    out_data_o = !empty ? mem_q[rd_q] : byp ? in_data_i : 3'b000;
    push = in_valid_i && in_ready_o && !(byp && out_ready_i);
    pop = out_valid_o && out_ready_i && !empty;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module hier_loopback_return #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic B_0_0,
  input  logic B_0_1,
  input  logic B_0_2,
  input  logic b_valid,
  output logic b_ready,
  output logic A_0_0,
  output logic A_0_1,
  output logic A_0_2,
  output logic a_valid,
  input  logic a_ready,
  input  logic D_0_0,
  input  logic D_0_1,
  input  logic D_0_2,
  input  logic d_valid,
  output logic d_ready,
  output logic C_0_0,
  output logic C_0_1,
  output logic C_0_2,
  output logic c_valid,
  input  logic c_ready
);
  logic [2:0] a_data, c_data;
  assign {A_0_0, A_0_1, A_0_2} = a_data;
  assign {C_0_0, C_0_1, C_0_2} = c_data;
  hier_loopback_fifo #(.DEPTH(DEPTH)) u_ba (
    .clk(clk), .rst_n(rst_n),
    .in_data_i({B_0_0, B_0_1, B_0_2}), .in_valid_i(b_valid), .in_ready_o(b_ready),
    .out_data_o(a_data), .out_valid_o(a_valid), .out_ready_i(a_ready)
  );
  hier_loopback_fifo #(.DEPTH(DEPTH)) u_dc (
    .clk(clk), .rst_n(rst_n),
    .in_data_i({D_0_0, D_0_1, D_0_2}), .in_valid_i(d_valid), .in_ready_o(d_ready),
    .out_data_o(c_data), .out_valid_o(c_valid), .out_ready_i(c_ready)
  );
endmodule

// File: tb/tb_hier_loopback_return.sv
// tb_hier_loopback_return: queue-model checked bench with directed pins and random traffic
module tb_hier_loopback_return;
  localparam int DEPTH = 4;
`ifdef HIER_LOOPBACK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] b_data = '0, d_data = '0, a_dat, c_dat;
  logic b_valid = 1'b0, a_ready = 1'b0, d_valid = 1'b0, c_ready = 1'b0;
  logic b_ready, a_valid, d_ready, c_valid;
  int checks = 0, errors = 0;
  int pin_ch = 0, pv = -1, pd = -1, pr = -1;
  logic [2:0] qa[$], qc[$];
  bit st_a, rm_a, st_c, rm_c;
  logic eva, era, evc, erc, gv, gr, mv, mr;
  logic [2:0] eda, edc, gd, md;

  hier_loopback_return #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .B_0_0(b_data[2]), .B_0_1(b_data[1]), .B_0_2(b_data[0]),
    .b_valid(b_valid), .b_ready(b_ready),
    .A_0_0(a_dat[2]), .A_0_1(a_dat[1]), .A_0_2(a_dat[0]),
    .a_valid(a_valid), .a_ready(a_ready),
    .D_0_0(d_data[2]), .D_0_1(d_data[1]), .D_0_2(d_data[0]),
    .d_valid(d_valid), .d_ready(d_ready),
    .C_0_0(c_dat[2]), .C_0_1(c_dat[1]), .C_0_2(c_dat[0]),
    .c_valid(c_valid), .c_ready(c_ready)
  );

  always #5 clk = ~clk;

  function automatic void exp_out(input int sz, input logic [2:0] fr, input logic iv, input logic [2:0] id,
                                  output logic ov, output logic [2:0] od, output logic ir);
    ir = sz != DEPTH;
    ov = sz != 0 || (BYP && iv);
    od = sz != 0 ? fr : (ov ? id : 3'b000);
  endfunction

  function automatic void act(input int sz, input logic iv, input logic ordy, output bit st, output bit rm);
    bit push, pop;
    push = iv && sz != DEPTH;
    pop = (sz != 0 || (BYP && iv)) && ordy;
    rm = pop && sz != 0;
    st = push && !(pop && sz == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qc.delete();
    end else begin
      act(qa.size(), b_valid, a_ready, st_a, rm_a);
      act(qc.size(), d_valid, c_ready, st_c, rm_c);
      if (rm_a) void'(qa.pop_front());
      if (st_a) qa.push_back(b_data);
      if (rm_c) void'(qc.pop_front());
      if (st_c) qc.push_back(d_data);
    end
  end

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_out(qa.size(), qa.size() != 0 ? qa[0] : 3'b000, b_valid, b_data, eva, eda, era);
    exp_out(qc.size(), qc.size() != 0 ? qc[0] : 3'b000, d_valid, d_data, evc, edc, erc);
    chk("a_valid", int'(a_valid), int'(eva));
    chk("A_data", int'(a_dat), int'(eda));
    chk("b_ready", int'(b_ready), int'(era));
    chk("c_valid", int'(c_valid), int'(evc));
    chk("C_data", int'(c_dat), int'(edc));
    chk("d_ready", int'(d_ready), int'(erc));
    gv = pin_ch != 0 ? c_valid : a_valid;
    gd = pin_ch != 0 ? c_dat : a_dat;
    gr = pin_ch != 0 ? d_ready : b_ready;
    mv = pin_ch != 0 ? evc : eva;
    md = pin_ch != 0 ? edc : eda;
    mr = pin_ch != 0 ? erc : era;
    if (pv >= 0) begin
      chk("pin_valid_dut", int'(gv), pv);
      chk("pin_valid_model", int'(mv), pv);
    end
    if (pd >= 0) begin
      chk("pin_data_dut", int'(gd), pd);
      chk("pin_data_model", int'(md), pd);
    end
    if (pr >= 0) begin
      chk("pin_ready_dut", int'(gr), pr);
      chk("pin_ready_model", int'(mr), pr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    pin_ch = 0;
    pv = -1;
    pd = -1;
    pr = -1;
  endtask

  initial begin
    repeat (2) begin
      cyc();
      pv = 0; pd = 0; pr = 1;
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      cyc();
      b_valid = 1'b1; b_data = 3'(i);
    end
    cyc();
    b_valid = 1'b0; pv = 1; pd = 3;
    cyc();
    rst_n = 1'b0; pv = 0; pd = 0; pr = 1;
    cyc();
    rst_n = 1'b1; b_valid = 1'b1; b_data = 3'b101; pv = int'(BYP); pd = BYP ? 5 : 0;
    cyc();
    b_valid = 1'b0; pv = 1; pd = 5;
    cyc();
    a_ready = 1'b1; pv = 1; pd = 5;
    cyc();
    a_ready = 1'b0; pv = 0; pd = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      b_valid = 1'b1; b_data = 3'(i);
    end
    cyc();
    b_data = 3'd5; pv = 1; pd = 1; pr = 0;
    cyc();
    pv = 1; pd = 1; pr = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      b_valid = 1'b0; a_ready = 1'b1; pv = 1; pd = i; pr = int'(i > 1);
    end
    cyc();
    a_ready = 1'b0; pv = 0; pd = 0; pr = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      b_valid = 1'b1; b_data = 3'(i);
    end
    for (int i = 2; i < 12; i++) begin
      cyc();
      b_data = 3'(i); a_ready = 1'b1; pv = 1; pd = (i - 2) % 8; pr = 1;
    end
    for (int i = 2; i < 4; i++) begin
      cyc();
      b_valid = 1'b0; pv = 1; pd = i;
    end
    cyc();
    a_ready = 1'b0; pv = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      d_valid = 1'b1; d_data = 3'(k + 1); c_ready = 1'b0;
      b_valid = 1'b1; b_data = 3'($urandom_range(0, 7)); a_ready = 1'b1;
      pin_ch = 1; pv = int'(k > 0 || BYP); pr = int'(k < 4);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      d_valid = 1'b0; b_valid = 1'b0; c_ready = 1'b1; pin_ch = 1; pv = 1; pd = k;
    end
    cyc();
    c_ready = 1'b0; a_ready = 1'b0; pin_ch = 1; pv = 0; pd = 0; pr = 1;
    cyc();
    b_valid = 1'b1; b_data = 3'b110; a_ready = 1'b1; pv = int'(BYP); pd = BYP ? 6 : 0;
    cyc();
    b_valid = 1'b0; pv = int'(!BYP); pd = BYP ? 0 : 6;
    cyc();
    a_ready = 1'b0; pv = 0;
    for (int n = 0; n < 2000; n++) begin
      cyc();
      rst_n = $urandom_range(0, 199) != 0;
      b_valid = $urandom_range(0, 3) != 0;
      d_valid = $urandom_range(0, 1) != 0;
      a_ready = $urandom_range(0, 2) != 0;
      c_ready = $urandom_range(0, 3) == 0;
      b_data = 3'($urandom_range(0, 7));
      d_data = 3'($urandom_range(0, 7));
    end
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
